// File: rtl/interrupt_controller.sv
// interrupt_controller
//   8051-style interrupt controller sitting in front of the CPU core. It
//   latches INT0/INT1 and the two timer overflows, holds the IE, IP and TCON
//   SFRs, arbitrates two priority levels and hands one vectored request to
//   the CPU. irq_ack and reti from the CPU drive the in-service tracking that
//   gives nesting.
//
// Ports
//   clk, reset              system clock, asynchronous active-high reset
//   int0_n, int1_n          external interrupts, active low, asynchronous
//   tf0_pulse, tf1_pulse    timer overflow pulses, one cycle
//   sfr_addr/wdata/we/re    SFR access port
//   sfr_rdata               registered read data, loaded the cycle after sfr_re
//   irq_req, irq_vector     request and vector to the CPU
//   irq_ack, reti           CPU acknowledge and return-from-interrupt pulses
//
// State | meaning
// IDLE  | no request outstanding; arbitrate every cycle
// REQ   | irq_req high for a locked source, waiting for irq_ack
module interrupt_controller #(
  parameter logic [7:0]  ADDR_TCON  = 8'h88,
  parameter logic [7:0]  ADDR_IE    = 8'hA8,
  parameter logic [7:0]  ADDR_IP    = 8'hB8,
  parameter int unsigned VEC_STRIDE = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        int0_n,
  input  logic        int1_n,
  input  logic        tf0_pulse,
  input  logic        tf1_pulse,
  input  logic [7:0]  sfr_addr,
  input  logic [7:0]  sfr_wdata,
  input  logic        sfr_we,
  input  logic        sfr_re,
  output logic [7:0]  sfr_rdata,
  output logic        irq_req,
  output logic [15:0] irq_vector,
  input  logic        irq_ack,
  input  logic        reti
);

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t state, state_nxt;

  // Source index order everywhere: 0 IE0, 1 TF0, 2 IE1, 3 TF1.
  // IE bits 3:0 and IP bits 3:0 happen to follow the same order.
  logic       ea;
  logic [3:0] en;
  logic [3:0] pri;
  logic [1:0] it;
  logic [1:0] tr;
  logic [3:0] flag;
  logic [3:0] flag_nxt;
  logic       in_svc_hi, in_svc_lo;
  logic       in_svc_hi_nxt, in_svc_lo_nxt;
  logic [1:0] sync1, sync2, sync_prev;
  logic [1:0] ext_fall;
  logic [1:0] lock_idx;
  logic       lock_hi;

  logic       wr_tcon, wr_ie, wr_ip;
  logic [3:0] elig, elig_hi, pick_set;
  logic       win_valid;
  logic [1:0] win_idx;
  logic       grant, ack_fire;
  logic [3:0] ack_clr, hw_set, sw_val;
  logic [7:0] rd_mux;

  assign wr_tcon = sfr_we && (sfr_addr == ADDR_TCON);
  assign wr_ie   = sfr_we && (sfr_addr == ADDR_IE);
  assign wr_ip   = sfr_we && (sfr_addr == ADDR_IP);

  // Two-flop synchronizer plus one history flop for falling-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1     <= 2'b11;
      sync2     <= 2'b11;
      sync_prev <= 2'b11;
    end else begin
      sync1     <= {int1_n, int0_n};
      sync2     <= sync1;
      sync_prev <= sync2;
    end
  end

  assign ext_fall = sync_prev & ~sync2;

  // A source may interrupt only if its level is above the level in service.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      elig[i] = flag[i] & en[i] & ea & ~in_svc_hi & (pri[i] | ~in_svc_lo);
    end
    elig_hi   = elig & pri;
    pick_set  = (|elig_hi) ? elig_hi : elig;
    win_valid = |elig;
    win_idx   = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pick_set[i]) win_idx = 2'(i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    ack_fire  = 1'b0;
    case (state)
      IDLE: begin
        if (win_valid) begin
          state_nxt = REQ;
          grant     = 1'b1;
        end
      end
      REQ: begin
        // Ack wins over a same-cycle loss of eligibility: the CPU has
        // already committed to the vector it saw.
        if (irq_ack) begin
          ack_fire  = 1'b1;
          state_nxt = IDLE;
        end else if (!elig[lock_idx]) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign irq_req = (state == REQ);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_vector <= 16'h0000;
      lock_idx   <= 2'd0;
      lock_hi    <= 1'b0;
    end else if (grant) begin
      irq_vector <= 16'h0003 + 16'(win_idx) * 16'(VEC_STRIDE);
      lock_idx   <= win_idx;
      lock_hi    <= pri[win_idx];
    end
  end

  // Flag update order: software write, then ack clear, then hardware set,
  // so a hardware event is never lost. Level-mode externals simply track
  // the pin and ignore everything else.
  assign ack_clr = ack_fire ? (4'b0001 << lock_idx) : 4'b0000;
  assign hw_set  = {tf1_pulse, ext_fall[1], tf0_pulse, ext_fall[0]};
  assign sw_val  = {sfr_wdata[7], sfr_wdata[3], sfr_wdata[5], sfr_wdata[1]};

  always_comb begin
    flag_nxt = flag;
    for (int i = 0; i < 4; i++) begin
      if (wr_tcon)    flag_nxt[i] = sw_val[i];
      if (ack_clr[i]) flag_nxt[i] = 1'b0;
      if (hw_set[i])  flag_nxt[i] = 1'b1;
    end
    if (!it[0]) flag_nxt[0] = ~sync2[0];
    if (!it[1]) flag_nxt[2] = ~sync2[1];
  end

  // reti releases the highest active level before an ack in the same cycle
  // claims a level.
  always_comb begin
    in_svc_hi_nxt = in_svc_hi;
    in_svc_lo_nxt = in_svc_lo;
    if (reti) begin
      if (in_svc_hi) in_svc_hi_nxt = 1'b0;
      else           in_svc_lo_nxt = 1'b0;
    end
    if (ack_fire) begin
      if (lock_hi) in_svc_hi_nxt = 1'b1;
      else         in_svc_lo_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ea        <= 1'b0;
      en        <= 4'h0;
      pri       <= 4'h0;
      it        <= 2'b00;
      tr        <= 2'b00;
      flag      <= 4'h0;
      in_svc_hi <= 1'b0;
      in_svc_lo <= 1'b0;
    end else begin
      if (wr_ie) begin
        ea <= sfr_wdata[7];
        en <= sfr_wdata[3:0];
      end
      if (wr_ip) pri <= sfr_wdata[3:0];
      if (wr_tcon) begin
        tr <= {sfr_wdata[6], sfr_wdata[4]};
        it <= {sfr_wdata[2], sfr_wdata[0]};
      end
      flag      <= flag_nxt;
      in_svc_hi <= in_svc_hi_nxt;
      in_svc_lo <= in_svc_lo_nxt;
    end
  end

  always_comb begin
    rd_mux = 8'h00;
    case (sfr_addr)
      ADDR_TCON: rd_mux = {flag[3], tr[1], flag[1], tr[0], flag[2], it[1], flag[0], it[0]};
      ADDR_IE:   rd_mux = {ea, 3'b000, en};
      ADDR_IP:   rd_mux = {4'h0, pri};
      default:   rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       sfr_rdata <= 8'h00;
    else if (sfr_re) sfr_rdata <= rd_mux;
  end

endmodule

// File: tb/tb_interrupt_controller.sv
module tb_interrupt_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        int0_n = 1'b1, int1_n = 1'b1;
  logic        tf0_pulse = 1'b0, tf1_pulse = 1'b0;
  logic [7:0]  sfr_addr = 8'h00, sfr_wdata = 8'h00;
  logic        sfr_we = 1'b0, sfr_re = 1'b0;
  logic [7:0]  sfr_rdata;
  logic        irq_req;
  logic [15:0] irq_vector;
  logic        irq_ack = 1'b0, reti = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  interrupt_controller dut (
    .clk(clk), .reset(reset), .int0_n(int0_n), .int1_n(int1_n),
    .tf0_pulse(tf0_pulse), .tf1_pulse(tf1_pulse),
    .sfr_addr(sfr_addr), .sfr_wdata(sfr_wdata), .sfr_we(sfr_we), .sfr_re(sfr_re),
    .sfr_rdata(sfr_rdata), .irq_req(irq_req), .irq_vector(irq_vector),
    .irq_ack(irq_ack), .reti(reti)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: run did not end, time=%0t required < 400000", $time);
    $fatal(1);
  end

  // ---------------- reference model ----------------
  // Sources are kept as arrays indexed 0 IE0, 1 TF0, 2 IE1, 3 TF1.
  // In-service state is viewed as a numeric level: 0 none, 1 low, 2 high;
  // a source of priority p has level p+1 and may interrupt only above it.
  bit          m_s1[2], m_s2[2], m_prev[2];
  bit          m_flag[4], m_en[4], m_pri[4];
  bit          m_ea;
  bit          m_it[2], m_tr[2];
  bit          m_hi, m_lo;
  bit          m_req, m_lock_hi;
  int          m_idx;
  logic [15:0] m_vec;
  logic [7:0]  m_rdata;

  function automatic logic [7:0] m_read(input logic [7:0] a);
    logic [7:0] v;
    v = 8'h00;
    if (a == 8'h88) v = {m_flag[3], m_tr[1], m_flag[1], m_tr[0], m_flag[2], m_it[1], m_flag[0], m_it[0]};
    if (a == 8'hA8) v = {m_ea, 3'b000, m_en[3], m_en[2], m_en[1], m_en[0]};
    if (a == 8'hB8) v = {4'h0, m_pri[3], m_pri[2], m_pri[1], m_pri[0]};
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_s1[i] = 1; m_s2[i] = 1; m_prev[i] = 1; m_it[i] = 0; m_tr[i] = 0;
    end
    for (int i = 0; i < 4; i++) begin
      m_flag[i] = 0; m_en[i] = 0; m_pri[i] = 0;
    end
    m_ea = 0; m_hi = 0; m_lo = 0; m_req = 0; m_lock_hi = 0; m_idx = 0;
    m_vec = 16'h0000; m_rdata = 8'h00;
  endtask

  task automatic model_step();
    int cur, best;
    bit elig[4];
    bit nflag[4];
    bit fall[2];
    bit ack_now, drop;
    cur = m_hi ? 2 : (m_lo ? 1 : 0);
    for (int i = 0; i < 4; i++)
      elig[i] = m_flag[i] && m_en[i] && m_ea && ((m_pri[i] ? 2 : 1) > cur);
    for (int x = 0; x < 2; x++) fall[x] = m_prev[x] && !m_s2[x];
    ack_now = m_req && irq_ack;
    drop    = m_req && !irq_ack && !elig[m_idx];
    if (sfr_re) m_rdata = m_read(sfr_addr);
    nflag = m_flag;
    if (sfr_we && sfr_addr == 8'h88) begin
      nflag[0] = sfr_wdata[1]; nflag[1] = sfr_wdata[5];
      nflag[2] = sfr_wdata[3]; nflag[3] = sfr_wdata[7];
    end
    if (ack_now) nflag[m_idx] = 0;
    if (tf0_pulse) nflag[1] = 1;
    if (tf1_pulse) nflag[3] = 1;
    for (int x = 0; x < 2; x++) begin
      if (m_it[x]) begin
        if (fall[x]) nflag[2*x] = 1;
      end else begin
        nflag[2*x] = !m_s2[x];
      end
    end
    if (reti) begin
      if (m_hi) m_hi = 0; else m_lo = 0;
    end
    if (ack_now) begin
      if (m_lock_hi) m_hi = 1; else m_lo = 1;
    end
    if (m_req) begin
      if (ack_now || drop) m_req = 0;
    end else begin
      best = -1;
      for (int lvl = 1; lvl >= 0; lvl--)
        for (int i = 0; i < 4; i++)
          if (best < 0 && elig[i] && int'(m_pri[i]) == lvl) best = i;
      if (best >= 0) begin
        m_req = 1; m_idx = best; m_vec = 16'(3 + 8 * best); m_lock_hi = m_pri[best];
      end
    end
    if (sfr_we) begin
      if (sfr_addr == 8'hA8) begin
        m_ea = sfr_wdata[7];
        for (int i = 0; i < 4; i++) m_en[i] = sfr_wdata[i];
      end
      if (sfr_addr == 8'hB8)
        for (int i = 0; i < 4; i++) m_pri[i] = sfr_wdata[i];
      if (sfr_addr == 8'h88) begin
        m_it[0] = sfr_wdata[0]; m_it[1] = sfr_wdata[2];
        m_tr[0] = sfr_wdata[4]; m_tr[1] = sfr_wdata[6];
      end
    end
    m_flag = nflag;
    m_prev = m_s2;
    m_s2   = m_s1;
    m_s1[0] = int0_n;
    m_s1[1] = int1_n;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) model_reset();
    else       model_step();
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    tf0_pulse = 0; tf1_pulse = 0; sfr_we = 0; sfr_re = 0;
    irq_ack = 0; reti = 0; sfr_addr = 8'h00; sfr_wdata = 8'h00;
  endtask

  task automatic do_reset();
    idle_inputs();
    int0_n = 1; int1_n = 1;
    reset = 1;
    @(negedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  task automatic sfr_write(input logic [7:0] a, input logic [7:0] d);
    sfr_addr = a; sfr_wdata = d; sfr_we = 1;
    tick();
    sfr_we = 0;
  endtask

  task automatic sfr_read(input logic [7:0] a, output logic [7:0] d);
    sfr_addr = a; sfr_re = 1;
    tick();
    sfr_re = 0;
    d = sfr_rdata;
  endtask

  task automatic pulse_ack();
    irq_ack = 1; tick(); irq_ack = 0;
  endtask

  task automatic pulse_reti();
    reti = 1; tick(); reti = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [7:0] d;
    do_reset();
    vectors++;
    if (irq_req !== 1'b0 || irq_vector !== 16'h0000 || sfr_rdata !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_outputs: req=%b vec=%h rdata=%h required 0/0000/00", irq_req, irq_vector, sfr_rdata);
    end
    sfr_read(8'hA8, d);
    vectors++;
    if (d !== 8'h00) begin miscompares++; $display("FAIL reset_ie: got %h required 00", d); end
    sfr_read(8'h88, d);
    vectors++;
    if (d !== 8'h00) begin miscompares++; $display("FAIL reset_tcon: got %h required 00", d); end
  endtask

  task automatic test_timer();
    logic [7:0] d;
    do_reset();
    sfr_write(8'hA8, 8'h82);
    tf0_pulse = 1; tick(); tf0_pulse = 0;
    vectors++;
    if (irq_req !== 1'b0) begin miscompares++; $display("FAIL timer_latency_early: req=%b required 0", irq_req); end
    tick();
    vectors++;
    if (irq_req !== 1'b1 || irq_vector !== 16'h000B) begin
      miscompares++; $display("FAIL timer_req: req=%b vec=%h required 1/000b", irq_req, irq_vector);
    end
    pulse_ack();
    vectors++;
    if (irq_req !== 1'b0) begin miscompares++; $display("FAIL timer_ack_drop: req=%b required 0", irq_req); end
    sfr_read(8'h88, d);
    vectors++;
    if (d !== 8'h00) begin miscompares++; $display("FAIL timer_tf0_cleared: tcon=%h required 00", d); end
  endtask

  task automatic test_ext();
    logic [7:0] d;
    do_reset();
    sfr_write(8'h88, 8'h01);
    sfr_write(8'hA8, 8'h81);
    int0_n = 0;
    tick(); tick(); tick();
    vectors++;
    if (irq_req !== 1'b0) begin miscompares++; $display("FAIL edge_latency_early: req=%b required 0", irq_req); end
    tick();
    vectors++;
    if (irq_req !== 1'b1 || irq_vector !== 16'h0003) begin
      miscompares++; $display("FAIL edge_req: req=%b vec=%h required 1/0003", irq_req, irq_vector);
    end
    pulse_ack();
    pulse_reti();
    sfr_write(8'h88, 8'h00);
    tick();
    vectors++;
    if (irq_req !== 1'b0) begin miscompares++; $display("FAIL edge_cleared_by_ack: req=%b required 0", irq_req); end
    tick();
    vectors++;
    if (irq_req !== 1'b1 || irq_vector !== 16'h0003) begin
      miscompares++; $display("FAIL level_req: req=%b vec=%h required 1/0003", irq_req, irq_vector);
    end
    pulse_ack();
    vectors++;
    if (irq_req !== 1'b0) begin miscompares++; $display("FAIL level_ack_drop: req=%b required 0", irq_req); end
    reti = 1; sfr_addr = 8'h88; sfr_re = 1;
    tick();
    reti = 0; sfr_re = 0;
    vectors++;
    if (sfr_rdata !== 8'h02 || irq_req !== 1'b0) begin
      miscompares++; $display("FAIL level_flag_kept: tcon=%h req=%b required 02/0", sfr_rdata, irq_req);
    end
    tick();
    vectors++;
    if (irq_req !== 1'b1) begin miscompares++; $display("FAIL level_rereq: req=%b required 1", irq_req); end
    int0_n = 1;
  endtask

  task automatic test_priority();
    do_reset();
    sfr_write(8'hA8, 8'h8F);
    tf0_pulse = 1; tf1_pulse = 1; tick(); tf0_pulse = 0; tf1_pulse = 0;
    tick();
    vectors++;
    if (irq_req !== 1'b1 || irq_vector !== 16'h000B) begin
      miscompares++; $display("FAIL prio_same_level: req=%b vec=%h required 1/000b", irq_req, irq_vector);
    end
    do_reset();
    sfr_write(8'hA8, 8'h8F);
    sfr_write(8'hB8, 8'h08);
    tf0_pulse = 1; tf1_pulse = 1; tick(); tf0_pulse = 0; tf1_pulse = 0;
    tick();
    vectors++;
    if (irq_req !== 1'b1 || irq_vector !== 16'h001B) begin
      miscompares++; $display("FAIL prio_high_wins: req=%b vec=%h required 1/001b", irq_req, irq_vector);
    end
  endtask

  task automatic test_nesting();
    do_reset();
    sfr_write(8'h88, 8'h04);
    sfr_write(8'hA8, 8'h8F);
    sfr_write(8'hB8, 8'h08);
    tf0_pulse = 1; tick(); tf0_pulse = 0;
    tick();
    vectors++;
    if (irq_vector !== 16'h000B || irq_req !== 1'b1) begin
      miscompares++; $display("FAIL nest_low_req: req=%b vec=%h required 1/000b", irq_req, irq_vector);
    end
    pulse_ack();
    tf1_pulse = 1; tick(); tf1_pulse = 0;
    tick();
    vectors++;
    if (irq_req !== 1'b1 || irq_vector !== 16'h001B) begin
      miscompares++; $display("FAIL nest_high_preempt: req=%b vec=%h required 1/001b", irq_req, irq_vector);
    end
    pulse_ack();
    int1_n = 0;
    for (int k = 0; k < 6; k++) tick();
    vectors++;
    if (irq_req !== 1'b0) begin miscompares++; $display("FAIL nest_blocked_hi: req=%b required 0", irq_req); end
    pulse_reti();
    tick();
    vectors++;
    if (irq_req !== 1'b0) begin miscompares++; $display("FAIL nest_blocked_lo: req=%b required 0", irq_req); end
    pulse_reti();
    vectors++;
    if (irq_req !== 1'b0) begin miscompares++; $display("FAIL nest_idle_cycle: req=%b required 0", irq_req); end
    tick();
    vectors++;
    if (irq_req !== 1'b1 || irq_vector !== 16'h0013) begin
      miscompares++; $display("FAIL nest_released: req=%b vec=%h required 1/0013", irq_req, irq_vector);
    end
    int1_n = 1;
  endtask

  task automatic test_cancel();
    logic [7:0] d;
    do_reset();
    sfr_write(8'hA8, 8'h82);
    tf0_pulse = 1; tick(); tf0_pulse = 0;
    tick();
    sfr_write(8'hA8, 8'h00);
    vectors++;
    if (irq_req !== 1'b1) begin miscompares++; $display("FAIL cancel_hold: req=%b required 1", irq_req); end
    tick();
    vectors++;
    if (irq_req !== 1'b0) begin miscompares++; $display("FAIL cancel_drop: req=%b required 0", irq_req); end
    pulse_ack();
    sfr_write(8'hA8, 8'h82);
    tick();
    vectors++;
    if (irq_req !== 1'b1 || irq_vector !== 16'h000B) begin
      miscompares++; $display("FAIL idle_ack_ignored: req=%b vec=%h required 1/000b", irq_req, irq_vector);
    end
    sfr_read(8'hA8, d);
    #2 reset = 1;
    #1;
    vectors++;
    if (irq_req !== 1'b0 || irq_vector !== 16'h0000 || sfr_rdata !== 8'h00) begin
      miscompares++;
      $display("FAIL async_reset: req=%b vec=%h rdata=%h required 0/0000/00", irq_req, irq_vector, sfr_rdata);
    end
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_sfr();
    logic [7:0] d;
    do_reset();
    sfr_write(8'hB8, 8'hFF);
    sfr_read(8'hB8, d);
    vectors++;
    if (d !== 8'h0F) begin miscompares++; $display("FAIL ip_read: got %h required 0f", d); end
    sfr_write(8'h00, 8'hFF);
    sfr_read(8'h00, d);
    vectors++;
    if (d !== 8'h00) begin miscompares++; $display("FAIL unmapped_read: got %h required 00", d); end
    sfr_write(8'hA8, 8'hFF);
    sfr_read(8'hA8, d);
    vectors++;
    if (d !== 8'h8F) begin miscompares++; $display("FAIL ie_read: got %h required 8f", d); end
    // Level-mode IE0/IE1 ignore the write (pins idle high); IT bits become 1.
    sfr_write(8'h88, 8'hFF);
    sfr_read(8'h88, d);
    vectors++;
    if (d !== 8'hF5) begin miscompares++; $display("FAIL tcon_read: got %h required f5", d); end
  endtask

  task automatic test_random();
    logic re_prev;
    logic [7:0] addrs [4];
    addrs[0] = 8'h88; addrs[1] = 8'hA8; addrs[2] = 8'hB8; addrs[3] = 8'h00;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(7) == 0) int0_n = ~int0_n;
      if ($urandom_range(7) == 0) int1_n = ~int1_n;
      tf0_pulse = ($urandom_range(15) == 0);
      tf1_pulse = ($urandom_range(15) == 0);
      irq_ack   = ($urandom_range(3) == 0);
      reti      = ($urandom_range(11) == 0);
      sfr_we    = ($urandom_range(15) == 0);
      sfr_re    = ($urandom_range(3) == 0);
      sfr_addr  = addrs[$urandom_range(3)];
      sfr_wdata = 8'($urandom);
      if (sfr_addr == 8'hA8 && $urandom_range(1) == 0) sfr_wdata[7] = 1'b1;
      re_prev = sfr_re;
      tick();
      vectors++;
      if (irq_req !== m_req) begin
        miscompares++; $display("FAIL rand_req: cycle %0d req=%b required %b", n, irq_req, m_req);
      end
      if (m_req) begin
        vectors++;
        if (irq_vector !== m_vec) begin
          miscompares++; $display("FAIL rand_vec: cycle %0d vec=%h required %h", n, irq_vector, m_vec);
        end
      end
      if (re_prev) begin
        vectors++;
        if (sfr_rdata !== m_rdata) begin
          miscompares++; $display("FAIL rand_rdata: cycle %0d rdata=%h required %h", n, sfr_rdata, m_rdata);
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_timer();
    test_ext();
    test_priority();
    test_nesting();
    test_cancel();
    test_sfr();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
